jtopl_dac_serial: RTL

- Transmit end of the mixed-sample path. Takes each signed parallel sample produced by the channel accumulator and converts it to 3-bit-exponent / 10-bit-mantissa floating point.
- Shifts the result out serially to an external YM3014-style DAC.
- Sits after the accumulator, in the same cenop domain.
- Has a one-entry holding buffer so a new sample can arrive mid-frame.

---
 rtl/jtopl_dac_serial.sv | 130 +++++++++++++
 1 files changed

// File: rtl/jtopl_dac_serial.sv
// Float encoder and serialiser feeding a YM3014-style DAC.
// Ports: clk, rst_n, cenop, snd/snd_vld in; busy, dac_sd/clk/sh, ovr out.
module jtopl_dac_serial #(
    parameter int INW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cenop,
    input  logic [INW-1:0] snd,
    input  logic           snd_vld,
    output logic           busy,
    output logic           dac_sd,
    output logic           dac_clk,
    output logic           dac_sh,
    output logic           ovr
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      st, st_nx;
    logic [12:0] word, word_nx;
    logic [12:0] buf_q, buf_nx;
    logic        buf_v, buf_v_nx;
    logic [3:0]  slot, slot_nx;
    logic        ph, ph_nx;
    logic        ovr_nx;

    logic signed [15:0] x;
    logic signed [15:0] t;
    logic [2:0]         enc_e;
    logic [9:0]         enc_m;
    logic [12:0]        enc;
    logic [15:0]        frame;
    logic               last;

    assign x = 16'($signed(snd));

    // Walk exponents downward so the smallest fitting one wins.
    always_comb begin
        enc_e = 3'd7;
        enc_m = 10'(x >>> 6);
        t     = '0;
        for (int i = 6; i >= 1; i--) begin
            t = x >>> (i - 1);
            if (t[15:9] == 7'h00 || t[15:9] == 7'h7f) begin
                enc_e = 3'(i);
                enc_m = t[9:0];
            end
        end
    end

    assign enc  = {enc_e, enc_m};
    assign last = (st == SHIFT) && (slot == 4'd15) && ph;

    always_comb begin
        st_nx    = st;
        word_nx  = word;
        buf_nx   = buf_q;
        buf_v_nx = buf_v;
        slot_nx  = slot;
        ph_nx    = ph;
        ovr_nx   = ovr;
        if (cenop) begin
            ovr_nx = 1'b0;
            unique case (st)
                IDLE: begin
                    if (snd_vld) begin
                        word_nx = enc;
                        slot_nx = '0;
                        ph_nx   = 1'b0;
                        st_nx   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        slot_nx = '0;
                        ph_nx   = 1'b0;
                        if (buf_v) begin
                            // A sample arriving now refills the slot just
                            // drained, so it is not an overrun.
                            word_nx  = buf_q;
                            buf_v_nx = snd_vld;
                            if (snd_vld) buf_nx = enc;
                        end else if (snd_vld) begin
                            word_nx = enc;
                        end else begin
                            st_nx = IDLE;
                        end
                    end else begin
                        {slot_nx, ph_nx} = {slot, ph} + 5'd1;
                        if (snd_vld) begin
                            buf_nx   = enc;
                            buf_v_nx = 1'b1;
                            ovr_nx   = buf_v;
                        end
                    end
                end
                default: st_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= IDLE;
            word  <= '0;
            buf_q <= '0;
            buf_v <= 1'b0;
            slot  <= '0;
            ph    <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            st    <= st_nx;
            word  <= word_nx;
            buf_q <= buf_nx;
            buf_v <= buf_v_nx;
            slot  <= slot_nx;
            ph    <= ph_nx;
            ovr   <= ovr_nx;
        end
    end

    // Three leading zero slots, then mantissa and exponent LSB first.
    assign frame   = {word, 3'b000};
    assign busy    = (st == SHIFT);
    assign dac_sd  = busy & frame[slot];
    assign dac_clk = busy & ph;
    assign dac_sh  = busy & (slot == 4'd15);

endmodule
